// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory port: funct3 widths, FSM states, store opcode.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RESP,
        S_MERGE,
        S_WR
    } state_e;

endpackage

// File: rtl/dmem_lane.sv
// Byte/half lane steering: left-justified load extract, sub-word store merge,
// and legality check of an incoming request.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [2:0]  req_f3_i,
    input  logic [1:0]  req_off_i,
    input  logic        req_store_i,
    input  logic [1:0]  op_size_i,
    input  logic [1:0]  op_off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o,
    output logic        misaligned_o
);

    // Extract the addressed lane to the top of the word, and splice store data into the old word.
    always_comb begin
        load_o  = word_i;
        merge_o = wdata_i;
        case (op_size_i)
            2'b00: begin
                load_o  = {word_i[{op_off_i, 3'b000} +: 8], 24'b0};
                merge_o = word_i;
                merge_o[{op_off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            2'b01: begin
                load_o  = {word_i[{op_off_i[1], 4'b0000} +: 16], 16'b0};
                merge_o = word_i;
                merge_o[{op_off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: ;
        endcase
    end

    // Reject misaligned halves/words, unknown encodings and unsigned-width stores.
    always_comb begin
        misaligned_o = 1'b1;
        case (req_f3_i)
            F3_B:    misaligned_o = 1'b0;
            F3_H:    misaligned_o = req_off_i[0];
            F3_W:    misaligned_o = |req_off_i;
            F3_BU:   misaligned_o = req_store_i;
            F3_HU:   misaligned_o = req_store_i | req_off_i[0];
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_port.sv
// Load/store responder for a single-port synchronous word SRAM; sub-word
// stores use read-modify-write and busy stalls the pipeline meanwhile.
module dmem_port
    import dmem_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [31:0]     wdata,
    output logic            busy,
    output logic [31:0]     mem_data,
    output logic            load_done,
    output logic            misaligned,
    output logic            ram_en,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [31:0]     ram_wdata,
    input  logic [31:0]     ram_rdata
);

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wd_q, wd_d;
    logic        ram_en_q, ram_en_d;
    logic        ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        load_done_q, load_done_d;
    logic        misaligned_q, misaligned_d;

    logic [31:0] lane_load, lane_merge;
    logic        req_bad;
    logic        unused_addr;

    // Upper address bits alias; they are intentionally not decoded.
    assign unused_addr = ^addr[XLEN-1:AW+2];

    dmem_lane u_lane (
        .req_f3_i     (funct3),
        .req_off_i    (addr[1:0]),
        .req_store_i  (is_store),
        .op_size_i    (size_q),
        .op_off_i     (off_q),
        .word_i       (ram_rdata),
        .wdata_i      (wd_q),
        .load_o       (lane_load),
        .merge_o      (lane_merge),
        .misaligned_o (req_bad)
    );

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        size_d       = size_q;
        off_d        = off_q;
        wd_d         = wd_q;
        ram_en_d     = ram_en_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        mem_data_d   = mem_data_q;
        load_done_d  = 1'b0;
        misaligned_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        misaligned_d = 1'b1;
                    end else begin
                        store_d    = is_store;
                        size_d     = funct3[1:0];
                        off_d      = addr[1:0];
                        wd_d       = wdata;
                        ram_addr_d = addr[AW+1:2];
                        ram_en_d   = 1'b1;
                        if (is_store && funct3 == F3_W) begin
                            ram_we_d    = 1'b1;
                            ram_wdata_d = wdata;
                            state_d     = S_WR;
                        end else begin
                            ram_we_d = 1'b0;
                            state_d  = S_RD;
                        end
                    end
                end
            end
            S_RD: begin
                ram_en_d = 1'b0;
                state_d  = store_q ? S_MERGE : S_RESP;
            end
            S_RESP: begin
                mem_data_d  = lane_load;
                load_done_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_MERGE: begin
                ram_wdata_d = lane_merge;
                ram_en_d    = 1'b1;
                ram_we_d    = 1'b1;
                state_d     = S_WR;
            end
            S_WR: begin
                ram_en_d = 1'b0;
                ram_we_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            store_q      <= 1'b0;
            size_q       <= '0;
            off_q        <= '0;
            wd_q         <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            mem_data_q   <= '0;
            load_done_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            size_q       <= size_d;
            off_q        <= off_d;
            wd_q         <= wd_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            mem_data_q   <= mem_data_d;
            load_done_q  <= load_done_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign mem_data   = mem_data_q;
    assign load_done  = load_done_q;
    assign misaligned = misaligned_q;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_dmem_port.sv
// Randomized and directed bench for dmem_port against a word-array reference model.
module tb_dmem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] mem_data;
    logic        load_done;
    logic        misaligned;
    logic        ram_en;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] ram     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_md;
    int          wr_cnt;
    int          n_checks;
    int          n_pass;

    dmem_port #(.XLEN(32), .AW(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .mem_data   (mem_data),
        .load_done  (load_done),
        .misaligned (misaligned),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port SRAM seen by the DUT.
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            ram[ram_addr] <= ram_wdata;
            wr_cnt        <= wr_cnt + 1;
        end else if (ram_en) begin
            ram_rdata <= ram[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic legal_f(input logic st, input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0:    return 1'b1;
            3'd1:    return a[0] == 1'b0;
            3'd2:    return a[1:0] == 2'b00;
            3'd4:    return !st;
            3'd5:    return !st && a[0] == 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_f(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        int unsigned sh;
        sh = 8 * a[1:0];
        if (f3 == 3'd0 || f3 == 3'd4) return ((w >> sh) & 32'hFF) << 24;
        if (f3 == 3'd1 || f3 == 3'd5) return ((w >> sh) & 32'hFFFF) << 16;
        return w;
    endfunction

    function automatic logic [31:0] merge_f(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [2:0] f3, input logic [31:0] a);
        int unsigned sh;
        logic [31:0] m;
        sh = 8 * a[1:0];
        if (f3 == 3'd2) return wd;
        m = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
        return (old & ~(m << sh)) | ((wd & m) << sh);
    endfunction

    // Issue one request, watch it for a fixed window, and compare against the model.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic        lg;
        int unsigned widx;
        int          busy_n, mis_n, ld_n, en_n, wr0, exp_busy;
        logic [31:0] exp_load;
        lg       = legal_f(st, f3, a);
        widx     = a[11:2];
        exp_load = load_f(ref_mem[widx], f3, a);
        exp_busy = !lg ? 0 : !st ? 2 : (f3 == 3'd2) ? 1 : 3;
        busy_n = 0; mis_n = 0; ld_n = 0; en_n = 0;
        @(negedge clk);
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        wr0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            busy_n += int'(busy);
            mis_n  += int'(misaligned);
            ld_n   += int'(load_done);
            en_n   += int'(ram_en);
            if (i == 0) begin
                check("misaligned_pulse", {31'b0, misaligned}, {31'b0, !lg});
                if (lg) check("ram_addr", {22'b0, ram_addr}, widx);
            end
            if (i == 2 && lg && !st) begin
                check("load_done_t2", {31'b0, load_done}, 32'd1);
                check("mem_data_t2", mem_data, exp_load);
            end
        end
        if (lg && !st) exp_md = exp_load;
        if (lg && st) ref_mem[widx] = merge_f(ref_mem[widx], wd, f3, a);
        check("busy_cycles", busy_n, exp_busy);
        check("misaligned_count", mis_n, !lg ? 1 : 0);
        check("load_done_count", ld_n, (lg && !st) ? 1 : 0);
        check("write_count", wr_cnt - wr0, (lg && st) ? 1 : 0);
        if (!lg) check("no_ram_en", en_n, 0);
        check("mem_data_hold", mem_data, exp_md);
        check("sram_word", ram[widx], ref_mem[widx]);
    endtask

    initial begin
        int wr0;
        n_checks = 0; n_pass = 0; wr_cnt = 0; exp_md = '0;
        req_valid = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        ram_rdata = '0;
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_load_done", {31'b0, load_done}, 32'd0);
        check("rst_misaligned", {31'b0, misaligned}, 32'd0);
        check("rst_ram_en", {31'b0, ram_en}, 32'd0);
        check("rst_ram_we", {31'b0, ram_we}, 32'd0);
        check("rst_ram_addr", {22'b0, ram_addr}, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed sequence.
        do_req(1'b1, 3'd2, 32'h8, 32'hDEADBEEF);
        do_req(1'b0, 3'd2, 32'h8, 32'h0);
        check("lw_deadbeef", mem_data, 32'hDEADBEEF);
        do_req(1'b1, 3'd0, 32'h9, 32'h55);
        check("sb_merge_word", ram[2], 32'hDEAD55EF);
        do_req(1'b0, 3'd4, 32'h9, 32'h0);
        check("lbu_9", mem_data, 32'h55000000);
        do_req(1'b0, 3'd1, 32'hA, 32'h0);
        check("lh_a", mem_data, 32'hDEAD0000);
        do_req(1'b0, 3'd2, 32'h6, 32'h0);
        do_req(1'b1, 3'd1, 32'h3, 32'h1234);
        check("misaligned_keeps_md", mem_data, 32'hDEAD0000);
        do_req(1'b1, 3'd2, 32'h1004, 32'hCAFEF00D);
        check("alias_word1", ram[1], 32'hCAFEF00D);
        do_req(1'b1, 3'd4, 32'h20, 32'h77);
        do_req(1'b0, 3'd3, 32'h20, 32'h0);

        // A request held while busy must be dropped.
        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b1; funct3 = 3'd0; addr = 32'h40; wdata = 32'hA5;
        wr0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        check("drop_busy", {31'b0, busy}, 32'd1);
        addr = 32'h44; funct3 = 3'd2; wdata = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        ref_mem[16] = merge_f(ref_mem[16], 32'hA5, 3'd0, 32'h40);
        check("drop_sb_word", ram[16], ref_mem[16]);
        check("drop_other_word", ram[17], ref_mem[17]);
        check("drop_write_count", wr_cnt - wr0, 1);

        // Reset during the MERGE cycle of a byte store.
        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b1; funct3 = 3'd0; addr = 32'h11; wdata = 32'h3C;
        wr0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_ram_en", {31'b0, ram_en}, 32'd0);
        check("mid_rst_ram_we", {31'b0, ram_we}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_mem_data", mem_data, 32'd0);
        exp_md = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_sram", ram[4], ref_mem[4]);
        check("mid_rst_no_write", wr_cnt - wr0, 0);
        check("mid_rst_load_done", {31'b0, load_done}, 32'd0);
        do_req(1'b0, 3'd2, 32'h10, 32'h0);

        // Randomized traffic over a small window of words with random upper address bits.
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_port.md
# dmem_port

Data-memory responder for the five-stage core's load/store path. It accepts one load or store request from the execute stage, runs it against a single-port synchronous word SRAM, and returns load data left-justified so that execute's sign/zero extension applies directly. Sub-word stores use read-modify-write, and `busy` stalls the pipeline while an access is in flight.

## Interface
- `XLEN`, 32: address and data width.
- `AW`, 10: SRAM word-address width (1024 words).

Ports (name, direction, width, meaning):
- `clk` in 1: clock; everything updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present this cycle.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU. For stores, only B, H and W are legal.
- `addr` in XLEN: byte address, taken from the ALU result.
- `wdata` in 32: store data, right-justified.
- `busy` out 1: access in flight; new requests are ignored.
- `mem_data` out 32: last load result, left-justified.
- `load_done` out 1: one-cycle pulse when `mem_data` updates.
- `misaligned` out 1: one-cycle pulse when an access is rejected.
- `ram_en` out 1: SRAM enable.
- `ram_we` out 1: SRAM write enable.
- `ram_addr` out AW: SRAM word address.
- `ram_wdata` out 32: SRAM write word.
- `ram_rdata` in 32: SRAM read word, valid the cycle after a read enable.

## Operation
- Byte order is little-endian within a word: byte k = `ram_rdata[8k+7:8k]`, with k = `addr[1:0]`.
- `ram_addr` = `addr[AW+1:2]`. Upper address bits are ignored, so addresses alias modulo 2^(AW+2).
- Load placement in `mem_data`:
  - B/BU: {byte k, 24'b0}.
  - H/HU: {half at `addr[1]`, 16'b0}.
  - W: the whole word.
- Extension is execute's job; this block never extends.
- Misaligned or illegal requests are rejected with no SRAM access:
  - H/HU with `addr[0]`=1.
  - W with `addr[1:0]`≠0.
  - Any other `funct3` encoding.
  - A store with a U encoding.
- A request is accepted only in IDLE with `req_valid`=1. Requests while `busy`=1 are dropped, so upstream holds its request until `busy` falls.
- FSM states are IDLE, RD, RESP, MERGE, WR. Transitions:
  - IDLE → RD on a legal load or sub-word store. Read outputs are driven: `ram_en`=1, `ram_we`=0.
  - IDLE → WR on a legal word store.
  - RD → RESP for a load.
  - RD → MERGE for a store.
  - RESP → IDLE. `mem_data` ← placed data; `load_done`=1.
  - MERGE → WR. `ram_wdata` ← `ram_rdata` with byte/half lane k replaced by `wdata[7:0]`/`wdata[15:0]`; `ram_en`=`ram_we`=1.
  - WR → IDLE. `ram_en`=`ram_we`=0.
- `busy` = (state ≠ IDLE).
- All SRAM-side outputs, `mem_data`, `load_done` and `misaligned` are registered.

## Timing
- Reset values: state IDLE; `busy`, `load_done`, `misaligned`, `ram_en`, `ram_we` = 0; `ram_addr`, `ram_wdata`, `mem_data` = 0.
- Latencies, counted in edges from the accept edge t0:
  - Load: SRAM read at t1, `mem_data`/`load_done` valid after t2. `busy` is high for 2 cycles.
  - Word store: SRAM write at t1. `busy` is high for 1 cycle.
  - Sub-word store: read at t1, merge at t2, write at t3. `busy` is high for 3 cycles.
  - Rejected access: `misaligned` pulses in the cycle after t0; `busy` stays 0; `mem_data` is unchanged.
- `mem_data` holds its value until the next `load_done`. Stores never alter it.
- Back-to-back requests: a request present in the first IDLE cycle after completion is accepted on that edge.
- Store followed by load to the same word: accesses are serialized, so the load returns the stored value.
- Reset asserted mid-access: `ram_en`/`ram_we` clear immediately. A pending write does not occur, and no pulse is emitted.

## Structure
- Shared package `dmem_pkg`:
  - `funct3` width constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - State enum.
  - Store opcode `7'b0100011`.
- Sub-module `dmem_lane` (combinational) produces:
  - the left-justified load extract from (word, `addr[1:0]`, `funct3`);
  - the store merge from (old word, `wdata`, `addr[1:0]`, `funct3`);
  - the `misaligned` flag.

## Test plan
- SW `addr`=0x8, `wdata`=0xDEADBEEF, then LW 0x8. Expected: `ram_addr`=2, one write, `busy` high 1 cycle; `mem_data`=0xDEADBEEF two edges after accept, with `load_done` pulsing.
- After the above, SB `addr`=0x9, `wdata`=0x55. Expected: RD/MERGE/WR sequence, SRAM word becomes 0xDEAD55EF, `busy` high 3 cycles. Then LBU 0x9 gives `mem_data`=0x55000000.
- LH `addr`=0xA on word 0xDEAD55EF. Expected: `mem_data`=0xDEAD0000.
- LW `addr`=0x6, and separately SH `addr`=0x3. Expected: `misaligned` pulses, `ram_en` never asserts, `mem_data` is unchanged.
- New request while `busy`=1. Expected: dropped. `addr`=0x1004 with AW=10 aliases to word 1.
- Assert `reset` during MERGE of an SB. Expected: all outputs 0 immediately, SRAM unchanged, FSM in IDLE after release.
